// File: rtl/mux_nx1_pipe.sv
// mux_nx1_pipe: N_IN-to-1 word selector feeding a 2-entry skid buffer.
// A push captures in_data[selector*WIDTH +: WIDTH] (all-zeros for an
// out-of-range selector); a pop hands the head word downstream and
// bumps the 16-bit wrapping xfer_count.
// Optional feature: define MUX_SEL_ERR_EN to enable the sticky sel_err
// flag for out-of-range selectors; otherwise sel_err is tied to 0.
module mux_nx1_pipe #(
  parameter int WIDTH = 32,
  parameter int N_IN  = 4,
  localparam int SEL_W = $clog2(N_IN)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]      selector,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [WIDTH-1:0]      data_out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  sel_err,
  output logic [15:0]           xfer_count
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] head, head_next;
  logic [WIDTH-1:0] tail, tail_next;
  logic [WIDTH-1:0] sel_word;
  logic             push, pop;

  // Handshake flags come from state only, so in_ready never sees out_ready.
  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign data_out  = out_valid ? head : '0;

  // Select the addressed input; no match (selector >= N_IN) yields zeros.
  always_comb begin
    sel_word = '0;
    for (int unsigned k = 0; k < N_IN; k++) begin
      if (selector == SEL_W'(k)) sel_word = in_data[k*WIDTH +: WIDTH];
    end
  end

  // Next-state and buffer-slot update for the two-entry skid buffer.
  always_comb begin
    state_next = state;
    head_next  = head;
    tail_next  = tail;
    unique case (state)
      EMPTY: begin
        if (push) begin
          head_next  = sel_word;
          state_next = ONE;
        end
      end
      ONE: begin
        if (push && pop) begin
          head_next  = sel_word;
        end else if (push) begin
          tail_next  = sel_word;
          state_next = FULL;
        end else if (pop) begin
          head_next  = '0;
          state_next = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          head_next  = tail;
          state_next = ONE;
        end
      end
      default: state_next = EMPTY;
    endcase
  end

  // State and data registers; reset discards any buffered words.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= EMPTY;
      head  <= '0;
      tail  <= '0;
    end else begin
      state <= state_next;
      head  <= head_next;
      tail  <= tail_next;
    end
  end

  // Completed output transfers, wrapping at 16 bits.
  always_ff @(posedge clk) begin
    if (reset)    xfer_count <= '0;
    else if (pop) xfer_count <= xfer_count + 16'd1;
  end

`ifdef MUX_SEL_ERR_EN
  logic sel_hit;

  // Selector addresses one of the real inputs.
  always_comb begin
    sel_hit = 1'b0;
    for (int unsigned k = 0; k < N_IN; k++) begin
      if (selector == SEL_W'(k)) sel_hit = 1'b1;
    end
  end

  // Sticky error flag: set by any out-of-range push, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset)                  sel_err <= 1'b0;
    else if (push && !sel_hit)  sel_err <= 1'b1;
  end
`else
  assign sel_err = 1'b0;
`endif

endmodule

// File: tb/tb_mux_nx1_pipe.sv
// Self-checking bench for mux_nx1_pipe: a queue-based transaction model
// predicts every output of the N_IN=4 instance each cycle; a second
// N_IN=5 instance exercises out-of-range selectors and sel_err.
module tb_mux_nx1_pipe;

  localparam int W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // N_IN = 4 instance
  logic [4*W-1:0] in_data;
  logic [1:0]     selector;
  logic           reset, in_valid, out_ready;
  logic           in_ready, out_valid, sel_err;
  logic [W-1:0]   data_out;
  logic [15:0]    xfer_count;

  // N_IN = 5 instance
  logic [5*W-1:0] in_data5;
  logic [2:0]     selector5;
  logic           reset5, in_valid5, out_ready5;
  logic           in_ready5, out_valid5, sel_err5;
  logic [W-1:0]   data_out5;
  logic [15:0]    xfer_count5;

  mux_nx1_pipe #(.WIDTH(W), .N_IN(4)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .selector(selector),
    .in_valid(in_valid), .in_ready(in_ready), .data_out(data_out),
    .out_valid(out_valid), .out_ready(out_ready), .sel_err(sel_err),
    .xfer_count(xfer_count)
  );

  mux_nx1_pipe #(.WIDTH(W), .N_IN(5)) dut5 (
    .clk(clk), .reset(reset5), .in_data(in_data5), .selector(selector5),
    .in_valid(in_valid5), .in_ready(in_ready5), .data_out(data_out5),
    .out_valid(out_valid5), .out_ready(out_ready5), .sel_err(sel_err5),
    .xfer_count(xfer_count5)
  );

`ifdef MUX_SEL_ERR_EN
  localparam logic SEL_ERR_EXP = 1'b1;
`else
  localparam logic SEL_ERR_EXP = 1'b0;
`endif

  localparam logic [W-1:0] D0 = 32'hA0A0_0001;
  localparam logic [W-1:0] D1 = 32'hB1B1_0002;
  localparam logic [W-1:0] D2 = 32'hC2C2_0003;
  localparam logic [W-1:0] D3 = 32'hD3D3_0004;

  int unsigned  total = 0;
  int unsigned  bad   = 0;
  logic [W-1:0] words [4];
  logic [W-1:0] words5 [5];
  logic [W-1:0] q [$];
  logic [15:0]  cnt;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic load_words(input logic [W-1:0] a, b, c, d);
    words[0] = a; words[1] = b; words[2] = c; words[3] = d;
    in_data  = {d, c, b, a};
  endtask

  task automatic load_random();
    load_words($urandom, $urandom, $urandom, $urandom);
  endtask

  task automatic check_model();
    chk("in_ready",   W'(in_ready),   W'(q.size() < 2));
    chk("out_valid",  W'(out_valid),  W'(q.size() > 0));
    chk("data_out",   data_out,       (q.size() > 0) ? q[0] : '0);
    chk("xfer_count", W'(xfer_count), W'(cnt));
    chk("sel_err4",   W'(sel_err),    '0);
  endtask

  // One clock of the N_IN=4 instance: predict from the queue, advance, compare.
  task automatic tick();
    bit           do_push, do_pop;
    logic [W-1:0] w;
    do_push = in_valid && (q.size() < 2);
    do_pop  = out_ready && (q.size() > 0);
    w       = words[selector];
    @(posedge clk);
    if (reset) begin
      q.delete();
      cnt = '0;
    end else begin
      if (do_pop) begin
        void'(q.pop_front());
        cnt = cnt + 16'd1;
      end
      if (do_push) q.push_back(w);
    end
    #1;
    check_model();
  endtask

  task automatic tick5();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b1; out_ready = 1'b0; selector = 2'd1;
    load_random();
    reset5 = 1'b1; in_valid5 = 1'b0; out_ready5 = 1'b0; selector5 = '0; in_data5 = '0;
    cnt = '0;

    // Reset state, with in_valid asserted during reset
    tick(); tick();
    reset = 1'b0; in_valid = 1'b0;
    tick();

    // Single push of input 2 with out_ready high
    load_words(D0, D1, D2, D3);
    selector = 2'd2; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    chk("single_d2", data_out, D2);
    in_valid = 1'b0;
    tick();
    chk("single_cnt", W'(xfer_count), 32'd1);
    chk("single_empty", W'(out_valid), 32'd0);

    // Back-pressure: fill with D0, D1; D3 waits for space
    out_ready = 1'b0; in_valid = 1'b1;
    selector = 2'd0; tick();
    selector = 2'd1; tick();
    chk("full_ready", W'(in_ready), 32'd0);
    selector = 2'd3; tick();
    chk("hold_d0", data_out, D0);
    out_ready = 1'b1; tick();
    chk("then_d1", data_out, D1);
    tick();
    chk("then_d3", data_out, D3);
    in_valid = 1'b0; tick();

    // Streaming: 100 back-to-back transfers, selector cycling 0..3
    reset = 1'b1; tick(); reset = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      load_random();
      selector = 2'(i % 4);
      tick();
    end
    in_valid = 1'b0; tick();
    chk("stream_cnt", W'(xfer_count), 32'd100);

    // Reset while FULL with in_valid high discards everything
    out_ready = 1'b0; in_valid = 1'b1;
    load_random(); tick(); load_random(); tick();
    chk("pre_rst_full", W'(in_ready), 32'd0);
    reset = 1'b1; tick();
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick();
    chk("post_rst_valid", W'(out_valid), 32'd0);

    // Randomized traffic with occasional reset
    for (int i = 0; i < 400; i++) begin
      load_random();
      selector  = 2'($urandom_range(0, 3));
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      reset     = ($urandom_range(0, 60) == 0);
      tick();
    end
    reset = 1'b0;

    // Counter wrap: 65535 pops reach 0xFFFF, one more wraps to 0
    reset = 1'b1; tick(); reset = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 65536; i++) begin
      selector = 2'(i % 4);
      tick();
    end
    chk("cnt_ffff", W'(xfer_count), 32'h0000_FFFF);
    tick();
    chk("cnt_wrap", W'(xfer_count), 32'h0000_0000);
    in_valid = 1'b0; tick();

    // N_IN=5: out-of-range selector captures zeros and flags sel_err
    for (int k = 0; k < 5; k++) words5[k] = $urandom | 32'h1;
    in_data5 = {words5[4], words5[3], words5[2], words5[1], words5[0]};
    tick5();
    reset5 = 1'b0; in_valid5 = 1'b1; selector5 = 3'd6; out_ready5 = 1'b0;
    tick5();
    in_valid5 = 1'b0;
    chk("oor_valid",  W'(out_valid5), 32'd1);
    chk("oor_zero",   data_out5,      '0);
    chk("oor_selerr", W'(sel_err5),   W'(SEL_ERR_EXP));
    tick5(); tick5();
    chk("selerr_sticky", W'(sel_err5), W'(SEL_ERR_EXP));
    out_ready5 = 1'b1; tick5();
    chk("oor_popped", W'(out_valid5), 32'd0);
    chk("oor_cnt",    W'(xfer_count5), 32'd1);
    in_valid5 = 1'b1; selector5 = 3'd4; out_ready5 = 1'b0;
    tick5();
    in_valid5 = 1'b0;
    chk("last_in",      data_out5,      words5[4]);
    chk("selerr_stays", W'(sel_err5),   W'(SEL_ERR_EXP));
    reset5 = 1'b1; tick5(); reset5 = 1'b0;
    chk("rst_selerr",  W'(sel_err5),   32'd0);
    chk("rst5_valid",  W'(out_valid5), 32'd0);
    chk("rst5_ready",  W'(in_ready5),  32'd1);
    chk("rst5_data",   data_out5,      '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
